// File: rtl/mult_sequencer.sv
// Control sequencer for the signed shift-add multiplier: turns Run / ClearA_LoadB
// levels into one clear, WIDTH add/sub slots and WIDTH shifts per Run assertion.
module mult_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic ClearA,
    output logic LoadB,
    output logic Add,
    output logic Sub,
    output logic Shift,
    output logic Busy,
    output logic Done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_ADD,
        S_SHIFT,
        S_HOLD
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last;

    assign last = (cnt_q == LAST);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ClearA  = 1'b0;
        LoadB   = 1'b0;
        Add     = 1'b0;
        Sub     = 1'b0;
        Shift   = 1'b0;
        Busy    = 1'b0;
        Done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Load request wins; a pending Run starts once the load level drops.
                if (ClearA_LoadB) begin
                    ClearA = 1'b1;
                    LoadB  = 1'b1;
                end else if (Run) begin
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                ClearA  = 1'b1;
                Busy    = 1'b1;
                cnt_d   = '0;
                state_d = S_ADD;
            end
            S_ADD: begin
                Busy    = 1'b1;
                Add     = M & ~last;
                Sub     = M & last;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                Busy  = 1'b1;
                Shift = 1'b1;
                if (last) begin
                    state_d = S_HOLD;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_ADD;
                end
            end
            S_HOLD: begin
                Done = 1'b1;
                if (!Run) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (Reset) begin
            ClearA = 1'b0;
            LoadB  = 1'b0;
            Add    = 1'b0;
            Sub    = 1'b0;
            Shift  = 1'b0;
            Busy   = 1'b0;
            Done   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: a behavioural A/B/X datapath answers the commands, and
// results are compared with plain signed multiplication and command-count rules.
module tb_mult_sequencer;

    localparam int W = 8;

    logic Clk = 1'b0;
    logic Reset = 1'b1, Run = 1'b0, ClearA_LoadB = 1'b0, M;
    logic ClearA, LoadB, Add, Sub, Shift, Busy, Done;

    logic [7:0] sw = '0, S = '0, A = '0, B = '0;
    logic       X = 1'b0;

    int n_total = 0, n_bad = 0;
    int cyc = 0;

    int n_clra = 0, n_loadb = 0, n_add = 0, n_sub = 0, n_shift = 0;
    int n_busy = 0, n_done = 0, n_viol = 0;
    int busy_rise = 0, done_rise = 0, sh_idx = 0;
    logic [7:0] add_mask = '0, sub_mask = '0;
    logic prev_busy = 1'b0, prev_done = 1'b0;
    logic c_clra = 1'b0, c_loadb = 1'b0, c_add = 1'b0, c_sub = 1'b0, c_shift = 1'b0;

    mult_sequencer #(.WIDTH(W)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
        .ClearA(ClearA), .LoadB(LoadB), .Add(Add), .Sub(Sub), .Shift(Shift),
        .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;
    assign M = B[0];

    always @(posedge Clk) cyc <= cyc + 1;

    // Sample the command outputs mid-cycle; tally them and remember them for the datapath.
    always @(negedge Clk) begin
        c_clra = ClearA; c_loadb = LoadB; c_add = Add; c_sub = Sub; c_shift = Shift;
        if (ClearA) n_clra++;
        if (LoadB)  n_loadb++;
        if (Add)    n_add++;
        if (Sub)    n_sub++;
        if (Shift)  n_shift++;
        if (Busy)   n_busy++;
        if (Done)   n_done++;
        if ((Add && Sub) || (Busy && Done)) n_viol++;
        if (Busy && !prev_busy) busy_rise = cyc;
        if (Done && !prev_done) done_rise = cyc;
        prev_busy = Busy;
        prev_done = Done;
        if (ClearA && Busy) begin
            sh_idx = 0; add_mask = '0; sub_mask = '0;
        end
        if (Add && sh_idx < W) add_mask[sh_idx] = 1'b1;
        if (Sub && sh_idx < W) sub_mask[sh_idx] = 1'b1;
        if (Shift) sh_idx++;
    end

    always @(posedge Clk) begin
        if (c_clra) begin
            A <= '0;
            X <= 1'b0;
        end
        if (c_loadb) B <= sw;
        if (c_add)      {X, A} <= {A[7], A} + {S[7], S};
        else if (c_sub) {X, A} <= {A[7], A} - {S[7], S};
        if (c_shift)    {X, A, B} <= {X, X, A, B[7:1]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // pre>0: Run and ClearA_LoadB high together for pre cycles; run_len: Run high cycles;
    // mid_clb: pulse ClearA_LoadB (with different switches) during the multiply.
    task automatic run_mult(input logic [7:0] b, input logic [7:0] s, input int pre,
                            input int run_len, input bit mid_clb);
        int s_clra, s_loadb, s_add, s_sub, s_shift, s_busy, s_done, s_viol;
        int nload, run_edge, prod, exp_done;
        logic [15:0] p;
        s_clra = n_clra; s_loadb = n_loadb; s_add = n_add; s_sub = n_sub;
        s_shift = n_shift; s_busy = n_busy; s_done = n_done; s_viol = n_viol;
        nload = (pre > 0) ? pre : 1;
        sw = b;
        ClearA_LoadB = 1'b1;
        Run = (pre > 0);
        repeat (nload) tick();
        ClearA_LoadB = 1'b0;
        S = s;
        Run = 1'b1;
        run_edge = cyc + 1;
        for (int i = 0; i < run_len; i++) begin
            if (mid_clb && i == 5) begin
                sw = ~b;
                ClearA_LoadB = 1'b1;
            end
            if (mid_clb && i == 8) ClearA_LoadB = 1'b0;
            tick();
        end
        Run = 1'b0;
        ClearA_LoadB = 1'b0;
        repeat (24) tick();

        prod = int'($signed(b)) * int'($signed(s));
        p = prod[15:0];
        exp_done = (run_len >= 18) ? run_len - 17 : 1;
        check("clra_cnt",  n_clra - s_clra, nload + 1);
        check("loadb_cnt", n_loadb - s_loadb, nload);
        check("add_cnt",   n_add - s_add, $countones(b[6:0]));
        check("sub_cnt",   n_sub - s_sub, b[7]);
        check("add_slots", add_mask, {1'b0, b[6:0]});
        check("sub_slot",  sub_mask, {b[7], 7'b0});
        check("shift_cnt", n_shift - s_shift, W);
        check("busy_len",  n_busy - s_busy, 1 + 2 * W);
        check("busy_start", busy_rise, run_edge);
        check("done_start", done_rise, run_edge + 1 + 2 * W);
        check("done_len",  n_done - s_done, exp_done);
        check("overlap",   n_viol - s_viol, 0);
        check("product",   {A, B}, p);
        check("sign_x",    X, p[15]);
    endtask

    initial begin
        int shifts, snap_add, snap_sub, snap_shift, snap_busy;
        bit hit;

        // Reset held with both control levels high: every output must stay low.
        Reset = 1'b1; Run = 1'b1; ClearA_LoadB = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check("reset_outs", {ClearA, LoadB, Add, Sub, Shift, Busy, Done}, 7'b0);
            @(posedge Clk); #1;
        end
        Reset = 1'b0; Run = 1'b0; ClearA_LoadB = 1'b0;
        @(negedge Clk);
        check("idle_outs", {ClearA, LoadB, Add, Sub, Shift, Busy, Done}, 7'b0);
        tick();
        ClearA_LoadB = 1'b1;
        @(negedge Clk);
        check("idle_load", {ClearA, LoadB, Busy}, 3'b110);
        tick();
        ClearA_LoadB = 1'b0;
        tick();

        run_mult(8'h03, 8'h07, 0, 30, 1'b0);
        run_mult(8'hFF, 8'hFF, 0, 30, 1'b0);
        run_mult(8'h03, 8'hF9, 0, 20, 1'b0);
        run_mult(8'h80, 8'h80, 0, 18, 1'b0);
        run_mult(8'h5A, 8'hC3, 2, 19, 1'b0);
        run_mult(8'hB7, 8'h6D, 0, 3, 1'b1);

        // Reset during the SHIFT with cnt=4 (fifth shift).
        ClearA_LoadB = 1'b1; sw = 8'h77; tick();
        ClearA_LoadB = 1'b0; S = 8'h35; Run = 1'b1;
        shifts = 0; hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge Clk);
            if (Shift) shifts++;
            if (shifts == 5) hit = 1'b1;
        end
        check("reset_reach", hit, 1'b1);
        #1 Reset = 1'b1; Run = 1'b0;
        tick();
        Reset = 1'b0;
        snap_add = n_add; snap_sub = n_sub; snap_shift = n_shift; snap_busy = n_busy;
        @(negedge Clk);
        check("post_reset", {ClearA, LoadB, Add, Sub, Shift, Busy, Done}, 7'b0);
        repeat (6) tick();
        check("post_reset_cmds", (n_add - snap_add) + (n_sub - snap_sub) + (n_shift - snap_shift), 0);
        check("post_reset_busy", n_busy - snap_busy, 0);
        run_mult(8'h9C, 8'h27, 0, 25, 1'b0);

        for (int k = 0; k < 20; k++) begin
            run_mult(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)),
                     int'($urandom_range(1, 30)), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
